// File: rtl/ex_stage_csr_if.sv
// Bundle between decode, the execute stage and the memory stage: ID->EX payload,
// registered EX->M copies, the ALU result and the machine-mode CSR access port.
interface ex_stage_csr_if;
  logic        enable;
  logic        valid_i;
  logic [63:0] pc_i;
  logic [31:0] instr_i;
  logic [4:0]  rd_i;
  logic [63:0] busa_i;
  logic [63:0] busb_i;
  logic [63:0] imm_i;
  logic        ALUSrcA_i;
  logic [1:0]  ALUSrcB_i;
  logic [4:0]  ALUOp_i;
  logic [1:0]  MulOp_i;
  logic [2:0]  MemOp_i;
  logic        MemToReg_i;
  logic        MemWen_i;
  logic        wen_i;
  logic        CsrToReg_i;
  logic        Ebreak_i;
  logic [63:0] Csrres_i;

  logic        valid_o;
  logic [63:0] pc_o;
  logic [31:0] instr_o;
  logic [4:0]  rd_o;
  logic [63:0] busb_o;
  logic [2:0]  MemOp_o;
  logic        MemToReg_o;
  logic        MemWen_o;
  logic        wen_o;
  logic        CsrToReg_o;
  logic [63:0] Csrres_o;
  logic        Ebreak_o;
  logic [63:0] ALURes;

  logic        Csrwen;
  logic [2:0]  CsrOp;
  logic [11:0] CsrId;
  logic [63:0] datain;
  logic        Ecall;
  logic [63:0] epc_in;
  logic [63:0] csrres;
  logic [63:0] mtvec_o;
  logic [63:0] mepc_o;

  modport master (
    output enable, valid_i, pc_i, instr_i, rd_i, busa_i, busb_i, imm_i,
           ALUSrcA_i, ALUSrcB_i, ALUOp_i, MulOp_i, MemOp_i, MemToReg_i,
           MemWen_i, wen_i, CsrToReg_i, Ebreak_i, Csrres_i,
           Csrwen, CsrOp, CsrId, datain, Ecall, epc_in,
    input  valid_o, pc_o, instr_o, rd_o, busb_o, MemOp_o, MemToReg_o,
           MemWen_o, wen_o, CsrToReg_o, Csrres_o, Ebreak_o, ALURes,
           csrres, mtvec_o, mepc_o
  );

  modport slave (
    input  enable, valid_i, pc_i, instr_i, rd_i, busa_i, busb_i, imm_i,
           ALUSrcA_i, ALUSrcB_i, ALUOp_i, MulOp_i, MemOp_i, MemToReg_i,
           MemWen_i, wen_i, CsrToReg_i, Ebreak_i, Csrres_i,
           Csrwen, CsrOp, CsrId, datain, Ecall, epc_in,
    output valid_o, pc_o, instr_o, rd_o, busb_o, MemOp_o, MemToReg_o,
           MemWen_o, wen_o, CsrToReg_o, Csrres_o, Ebreak_o, ALURes,
           csrres, mtvec_o, mepc_o
  );
endinterface

// File: rtl/ex_stage_csr.sv
// RV64IM execute stage: ID->EX pipeline register, combinational ALU/MUL/DIV
// with 32-bit word mode, and the machine-mode CSR file (mstatus/mtvec/mepc/mcause).
module ex_stage_csr #(
  parameter int XLEN = 64
) (
  input logic          clk,
  input logic          rst,
  ex_stage_csr_if.slave bus
);
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [XLEN-1:0] MSTATUS_RST = 64'h0000000A00001800;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            r_valid, r_srca, r_memtoreg, r_memwen, r_wen, r_csrtoreg, r_ebreak;
  logic [XLEN-1:0] r_pc, r_busa, r_busb, r_imm, r_csrres;
  logic [31:0]     r_instr;
  logic [4:0]      r_rd, r_aluop;
  logic [1:0]      r_srcb, r_mulop;
  logic [2:0]      r_memop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;  r_pc <= '0;  r_instr <= '0;  r_rd <= '0;
      r_busa <= '0;  r_busb <= '0;  r_imm <= '0;  r_srca <= 1'b0;
      r_srcb <= '0;  r_aluop <= '0;  r_mulop <= '0;  r_memop <= '0;
      r_memtoreg <= 1'b0;  r_memwen <= 1'b0;  r_wen <= 1'b0;
      r_csrtoreg <= 1'b0;  r_ebreak <= 1'b0;  r_csrres <= '0;
    end else if (bus.enable) begin
      r_valid <= bus.valid_i;  r_pc <= bus.pc_i;  r_instr <= bus.instr_i;
      r_rd <= bus.rd_i;  r_busa <= bus.busa_i;  r_busb <= bus.busb_i;
      r_imm <= bus.imm_i;  r_srca <= bus.ALUSrcA_i;  r_srcb <= bus.ALUSrcB_i;
      r_aluop <= bus.ALUOp_i;  r_mulop <= bus.MulOp_i;  r_memop <= bus.MemOp_i;
      r_memtoreg <= bus.MemToReg_i;  r_memwen <= bus.MemWen_i;  r_wen <= bus.wen_i;
      r_csrtoreg <= bus.CsrToReg_i;  r_ebreak <= bus.Ebreak_i;  r_csrres <= bus.Csrres_i;
    end
  end

  assign bus.valid_o    = r_valid;
  assign bus.pc_o       = r_pc;
  assign bus.instr_o    = r_instr;
  assign bus.rd_o       = r_rd;
  assign bus.busb_o     = r_busb;
  assign bus.MemOp_o    = r_memop;
  assign bus.MemToReg_o = r_memtoreg;
  assign bus.MemWen_o   = r_memwen;
  assign bus.wen_o      = r_wen;
  assign bus.CsrToReg_o = r_csrtoreg;
  assign bus.Csrres_o   = r_csrres;
  assign bus.Ebreak_o   = r_ebreak;

  logic              w_word, w_b_zero, w_ovf;
  logic [5:0]        w_shamt;
  logic [XLEN-1:0]   w_a, w_b, w_as, w_bs, w_au, w_bu, w_bs_safe, w_bu_safe;
  logic [XLEN-1:0]   w_q_s, w_r_s, w_q_u, w_r_u, w_raw;
  logic [2*XLEN-1:0] w_p_ss, w_p_su, w_p_uu;

  assign w_a = r_srca ? r_pc : r_busa;
  always_comb begin
    case (r_srcb)
      2'b00:   w_b = r_busb;
      2'b01:   w_b = r_imm;
      2'b10:   w_b = XLEN'(4);
      default: w_b = '0;
    endcase
  end

  // Word mode pre-extends operands so one 64-bit datapath serves both widths.
  assign w_word  = (r_mulop == 2'b01);
  assign w_as    = w_word ? {{32{w_a[31]}}, w_a[31:0]} : w_a;
  assign w_bs    = w_word ? {{32{w_b[31]}}, w_b[31:0]} : w_b;
  assign w_au    = w_word ? {32'b0, w_a[31:0]} : w_a;
  assign w_bu    = w_word ? {32'b0, w_b[31:0]} : w_b;
  assign w_shamt = w_word ? {1'b0, w_b[4:0]} : w_b[5:0];

  assign w_p_ss = $signed({{XLEN{w_as[XLEN-1]}}, w_as}) * $signed({{XLEN{w_bs[XLEN-1]}}, w_bs});
  assign w_p_su = $signed({{XLEN{w_as[XLEN-1]}}, w_as}) * $signed({{XLEN{1'b0}}, w_bu});
  assign w_p_uu = {{XLEN{1'b0}}, w_au} * {{XLEN{1'b0}}, w_bu};

  // Divisor forced to 1 on the special cases so the divider never sees /0 or overflow.
  assign w_b_zero  = (w_bu == '0);
  assign w_ovf     = (w_as == MIN_NEG) && (w_bs == '1);
  assign w_bs_safe = (w_b_zero || w_ovf) ? XLEN'(1) : w_bs;
  assign w_bu_safe = w_b_zero ? XLEN'(1) : w_bu;
  assign w_q_s = $signed(w_as) / $signed(w_bs_safe);
  assign w_r_s = $signed(w_as) % $signed(w_bs_safe);
  assign w_q_u = w_au / w_bu_safe;
  assign w_r_u = w_au % w_bu_safe;

  always_comb begin
    case (r_aluop)
      5'd0:    w_raw = w_a + w_b;
      5'd1:    w_raw = w_a - w_b;
      5'd2:    w_raw = w_a << w_shamt;
      5'd3:    w_raw = {{(XLEN-1){1'b0}}, $signed(w_as) < $signed(w_bs)};
      5'd4:    w_raw = {{(XLEN-1){1'b0}}, w_au < w_bu};
      5'd5:    w_raw = w_a ^ w_b;
      5'd6:    w_raw = w_au >> w_shamt;
      5'd7:    w_raw = $signed(w_as) >>> w_shamt;
      5'd8:    w_raw = w_a | w_b;
      5'd9:    w_raw = w_a & w_b;
      5'd10:   w_raw = w_b;
      5'd16:   w_raw = w_p_ss[XLEN-1:0];
      5'd17:   w_raw = w_word ? (w_p_ss[XLEN-1:0] >> 32) : w_p_ss[2*XLEN-1:XLEN];
      5'd18:   w_raw = w_word ? (w_p_su[XLEN-1:0] >> 32) : w_p_su[2*XLEN-1:XLEN];
      5'd19:   w_raw = w_word ? (w_p_uu[XLEN-1:0] >> 32) : w_p_uu[2*XLEN-1:XLEN];
      5'd20:   w_raw = w_b_zero ? '1 : (w_ovf ? w_as : w_q_s);
      5'd21:   w_raw = w_b_zero ? '1 : w_q_u;
      5'd22:   w_raw = w_b_zero ? w_as : (w_ovf ? '0 : w_r_s);
      5'd23:   w_raw = w_b_zero ? w_au : w_r_u;
      default: w_raw = '0;
    endcase
  end

  assign bus.ALURes = w_word ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;

  logic [XLEN-1:0] r_mstatus, r_mtvec, r_mepc, r_mcause, w_csr_old, w_csr_new;
  logic            w_csr_wr;

  always_comb begin
    case (bus.CsrId)
      CSR_MSTATUS: w_csr_old = r_mstatus;
      CSR_MTVEC:   w_csr_old = r_mtvec;
      CSR_MEPC:    w_csr_old = r_mepc;
      CSR_MCAUSE:  w_csr_old = r_mcause;
      default:     w_csr_old = '0;
    endcase
  end

  always_comb begin
    w_csr_wr  = 1'b1;
    w_csr_new = w_csr_old;
    case (bus.CsrOp)
      3'b001:  w_csr_new = bus.datain;
      3'b010:  w_csr_new = w_csr_old | bus.datain;
      3'b011:  w_csr_new = w_csr_old & ~bus.datain;
      default: w_csr_wr  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus <= MSTATUS_RST;
      r_mtvec   <= '0;
      r_mepc    <= '0;
      r_mcause  <= '0;
    end else if (bus.Csrwen) begin
      if (bus.Ecall) begin
        r_mepc   <= bus.epc_in;
        r_mcause <= XLEN'(11);
      end else if (w_csr_wr) begin
        case (bus.CsrId)
          CSR_MSTATUS: r_mstatus <= w_csr_new;
          CSR_MTVEC:   r_mtvec   <= w_csr_new;
          CSR_MEPC:    r_mepc    <= w_csr_new;
          CSR_MCAUSE:  r_mcause  <= w_csr_new;
          default:     ;
        endcase
      end
    end
  end

  assign bus.csrres  = w_csr_old;
  assign bus.mtvec_o = r_mtvec;
  assign bus.mepc_o  = r_mepc;
endmodule

// File: tb/tb_ex_stage_csr.sv
// Bench for ex_stage_csr: directed checks of the key corner cases followed by
// randomized cycles compared against an arithmetic reference model.
module tb_ex_stage_csr;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  ex_stage_csr_if bus();

  ex_stage_csr #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] MINV = 64'h8000000000000000;

  // Reference state: what the stage should hold after each edge.
  logic        m_known = 1'b0;
  logic        m_valid, m_srca, m_memtoreg, m_memwen, m_wen, m_csrtoreg, m_ebreak;
  logic [63:0] m_pc, m_busa, m_busb, m_imm, m_csrres;
  logic [31:0] m_instr;
  logic [4:0]  m_rd, m_aluop;
  logic [1:0]  m_srcb, m_mulop;
  logic [2:0]  m_memop;
  logic [63:0] m_csr [logic [11:0]];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  function automatic logic [63:0] csr_read(input logic [11:0] id);
    if (m_csr.exists(id)) return m_csr[id];
    return 64'd0;
  endfunction

  function automatic logic [63:0] ref_d(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    logic [127:0] pu;
    logic [63:0] hu, r;
    sa = a;  sb = b;
    pu = {64'd0, a} * {64'd0, b};
    hu = pu[127:64];
    r  = 64'd0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << b[5:0];
      5'd3:  r = (sa < sb) ? 64'd1 : 64'd0;
      5'd4:  r = (a < b) ? 64'd1 : 64'd0;
      5'd5:  r = a ^ b;
      5'd6:  r = a >> b[5:0];
      5'd7:  r = sa >>> b[5:0];
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd10: r = b;
      5'd16: r = pu[63:0];
      // Signed high products derived from the unsigned one by two's-complement correction.
      5'd17: r = hu - ((sa < 0) ? b : 64'd0) - ((sb < 0) ? a : 64'd0);
      5'd18: r = hu - ((sa < 0) ? b : 64'd0);
      5'd19: r = hu;
      5'd20: if (b == 64'd0) r = '1; else if (a == MINV && b == '1) r = a; else r = sa / sb;
      5'd21: if (b == 64'd0) r = '1; else r = a / b;
      5'd22: if (b == 64'd0) r = a; else if (a == MINV && b == '1) r = 64'd0; else r = sa % sb;
      5'd23: if (b == 64'd0) r = a; else r = a % b;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ref_w(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      p;
    logic [31:0] r;
    sa = a;  sb = b;  r = 32'd0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << b[4:0];
      5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  r = (a < b) ? 32'd1 : 32'd0;
      5'd5:  r = a ^ b;
      5'd6:  r = a >> b[4:0];
      5'd7:  r = sa >>> b[4:0];
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd10: r = b;
      5'd16: r = a * b;
      5'd17: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
      5'd18: begin p = longint'(sa) * longint'({32'd0, b}); r = p[63:32]; end
      5'd19: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); r = p[63:32]; end
      5'd20: if (b == 32'd0) r = '1; else if (a == 32'h80000000 && b == '1) r = a; else r = sa / sb;
      5'd21: if (b == 32'd0) r = '1; else r = a / b;
      5'd22: if (b == 32'd0) r = a; else if (a == 32'h80000000 && b == '1) r = 32'd0; else r = sa % sb;
      5'd23: if (b == 32'd0) r = a; else r = a % b;
      default: r = 32'd0;
    endcase
    return {{32{r[31]}}, r};
  endfunction

  function automatic logic [63:0] ref_alu();
    logic [63:0] a, b;
    a = m_srca ? m_pc : m_busa;
    case (m_srcb)
      2'd0: b = m_busb;
      2'd1: b = m_imm;
      2'd2: b = 64'd4;
      default: b = 64'd0;
    endcase
    if (m_mulop == 2'b01) return ref_w(m_aluop, a[31:0], b[31:0]);
    return ref_d(m_aluop, a, b);
  endfunction

  // One clock: check the combinational CSR read, advance the model, then check all outputs.
  task automatic tick();
    #2;
    if (m_known) check_eq("csrres_pre", bus.csrres, csr_read(bus.CsrId));
    if (rst) begin
      {m_valid, m_srca, m_memtoreg, m_memwen, m_wen, m_csrtoreg, m_ebreak} = '0;
      m_pc = 0;  m_busa = 0;  m_busb = 0;  m_imm = 0;  m_csrres = 0;
      m_instr = 0;  m_rd = 0;  m_aluop = 0;  m_srcb = 0;  m_mulop = 0;  m_memop = 0;
      m_csr.delete();
      m_csr[12'h300] = 64'h0000000A00001800;
      m_csr[12'h305] = 64'd0;
      m_csr[12'h341] = 64'd0;
      m_csr[12'h342] = 64'd0;
      m_known = 1'b1;
    end else begin
      if (bus.enable) begin
        m_valid = bus.valid_i;  m_pc = bus.pc_i;  m_instr = bus.instr_i;  m_rd = bus.rd_i;
        m_busa = bus.busa_i;  m_busb = bus.busb_i;  m_imm = bus.imm_i;
        m_srca = bus.ALUSrcA_i;  m_srcb = bus.ALUSrcB_i;  m_aluop = bus.ALUOp_i;
        m_mulop = bus.MulOp_i;  m_memop = bus.MemOp_i;  m_memtoreg = bus.MemToReg_i;
        m_memwen = bus.MemWen_i;  m_wen = bus.wen_i;  m_csrtoreg = bus.CsrToReg_i;
        m_ebreak = bus.Ebreak_i;  m_csrres = bus.Csrres_i;
      end
      if (bus.Csrwen) begin
        if (bus.Ecall) begin
          m_csr[12'h341] = bus.epc_in;
          m_csr[12'h342] = 64'd11;
        end else if (m_csr.exists(bus.CsrId)) begin
          case (bus.CsrOp)
            3'b001: m_csr[bus.CsrId] = bus.datain;
            3'b010: m_csr[bus.CsrId] = m_csr[bus.CsrId] | bus.datain;
            3'b011: m_csr[bus.CsrId] = m_csr[bus.CsrId] & ~bus.datain;
            default: ;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    n_txn++;
    check_eq("valid_o", {63'd0, bus.valid_o}, {63'd0, m_valid});
    check_eq("pc_o", bus.pc_o, m_pc);
    check_eq("instr_o", {32'd0, bus.instr_o}, {32'd0, m_instr});
    check_eq("busb_o", bus.busb_o, m_busb);
    check_eq("ctrl_o", {51'd0, bus.MemToReg_o, bus.MemWen_o, bus.wen_o, bus.CsrToReg_o, bus.Ebreak_o, bus.MemOp_o, bus.rd_o},
             {51'd0, m_memtoreg, m_memwen, m_wen, m_csrtoreg, m_ebreak, m_memop, m_rd});
    check_eq("Csrres_o", bus.Csrres_o, m_csrres);
    check_eq("ALURes", bus.ALURes, ref_alu());
    check_eq("mtvec_o", bus.mtvec_o, csr_read(12'h305));
    check_eq("mepc_o", bus.mepc_o, csr_read(12'h341));
    $display("txn %0d rst=%0b en=%0b op=%0d mop=%0d alures=%h mepc=%h", n_txn, rst, bus.enable,
             m_aluop, m_mulop, bus.ALURes, bus.mepc_o);
  endtask

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = MINV;
      3: v = 64'h0000000080000000;
      4: v = {32'hFFFFFFFF, $urandom()};
      5: v = 64'($urandom_range(0, 20));
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  function automatic logic [11:0] rand_csr_id();
    case ($urandom_range(0, 4))
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h341;
      3: return 12'h342;
      default: return 12'($urandom());
    endcase
  endfunction

  task automatic set_alu(input logic srca, input logic [1:0] srcb, input logic [4:0] op, input logic [1:0] mop,
                         input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm);
    bus.ALUSrcA_i = srca;  bus.ALUSrcB_i = srcb;  bus.ALUOp_i = op;  bus.MulOp_i = mop;
    bus.pc_i = pc;  bus.busa_i = a;  bus.busb_i = b;  bus.imm_i = imm;
  endtask

  initial begin
    int k;
    bus.enable = 1'b1;  bus.valid_i = 1'b1;  bus.instr_i = 32'h13;  bus.rd_i = 5'd1;
    set_alu(1'b0, 2'd0, 5'd0, 2'd0, 64'h1234, 64'd5, 64'd6, 64'd7);
    bus.MemOp_i = 3'd0;  bus.MemToReg_i = 1'b0;  bus.MemWen_i = 1'b0;  bus.wen_i = 1'b1;
    bus.CsrToReg_i = 1'b0;  bus.Ebreak_i = 1'b0;  bus.Csrres_i = 64'd0;
    bus.Csrwen = 1'b0;  bus.CsrOp = 3'd0;  bus.CsrId = 12'h300;  bus.datain = 64'd0;
    bus.Ecall = 1'b0;  bus.epc_in = 64'd0;

    // Reset wins over enable/valid.
    rst = 1'b1;
    tick();
    check_eq("rst_valid", {63'd0, bus.valid_o}, 64'd0);
    check_eq("rst_pc", bus.pc_o, 64'd0);
    check_eq("rst_mstatus", bus.csrres, 64'h0000000A00001800);
    check_eq("rst_mtvec", bus.mtvec_o, 64'd0);
    rst = 1'b0;

    // Stall holds every field.
    bus.pc_i = 64'h80000000;  bus.valid_i = 1'b1;
    tick();
    check_eq("load_pc", bus.pc_o, 64'h80000000);
    bus.enable = 1'b0;  bus.pc_i = 64'h80000004;  bus.valid_i = 1'b0;
    tick();
    check_eq("stall_pc", bus.pc_o, 64'h80000000);
    check_eq("stall_valid", {63'd0, bus.valid_o}, 64'd1);
    bus.enable = 1'b1;  bus.valid_i = 1'b1;

    set_alu(1'b0, 2'd1, 5'd3, 2'd0, 64'd0, -64'sd5, 64'd0, 64'd3);
    tick();  check_eq("slt_neg", bus.ALURes, 64'd1);
    bus.ALUOp_i = 5'd4;
    tick();  check_eq("sltu_neg", bus.ALURes, 64'd0);
    bus.ALUOp_i = 5'd7;
    tick();  check_eq("sra_neg", bus.ALURes, '1);
    set_alu(1'b1, 2'd2, 5'd0, 2'd0, 64'h80000010, 64'd0, 64'd0, 64'd0);
    tick();  check_eq("pc_plus4", bus.ALURes, 64'h80000014);
    set_alu(1'b0, 2'd1, 5'd0, 2'd1, 64'd0, 64'h7FFFFFFF, 64'd0, 64'd1);
    tick();  check_eq("addw_ovf", bus.ALURes, 64'hFFFFFFFF80000000);

    set_alu(1'b0, 2'd0, 5'd20, 2'd0, 64'd0, 64'd123, 64'd0, 64'd0);
    tick();  check_eq("div_zero", bus.ALURes, '1);
    set_alu(1'b0, 2'd0, 5'd22, 2'd0, 64'd0, 64'd7, 64'd0, 64'd0);
    tick();  check_eq("rem_zero", bus.ALURes, 64'd7);
    set_alu(1'b0, 2'd0, 5'd20, 2'd0, 64'd0, MINV, '1, 64'd0);
    tick();  check_eq("div_ovf", bus.ALURes, MINV);
    set_alu(1'b0, 2'd0, 5'd19, 2'd0, 64'd0, '1, '1, 64'd0);
    tick();  check_eq("mulhu_ones", bus.ALURes, 64'hFFFFFFFFFFFFFFFE);

    // CSR read-before-write and set/clear.
    bus.Csrwen = 1'b1;  bus.CsrOp = 3'b001;  bus.CsrId = 12'h305;  bus.datain = 64'h80000100;
    #1;  check_eq("csrrw_old", bus.csrres, 64'd0);
    tick();  check_eq("csrrw_mtvec", bus.mtvec_o, 64'h80000100);
    bus.CsrOp = 3'b010;  bus.CsrId = 12'h300;  bus.datain = 64'h8;
    tick();  bus.Csrwen = 1'b0;  #1;
    check_eq("csrrs_mstatus", bus.csrres, 64'h0000000A00001808);
    bus.Csrwen = 1'b1;  bus.CsrOp = 3'b011;
    tick();  bus.Csrwen = 1'b0;  #1;
    check_eq("csrrc_mstatus", bus.csrres, 64'h0000000A00001800);

    // Ecall overrides the CSR op; without Csrwen it does nothing.
    bus.Csrwen = 1'b1;  bus.Ecall = 1'b1;  bus.epc_in = 64'h80000020;
    bus.CsrOp = 3'b001;  bus.CsrId = 12'h305;  bus.datain = 64'hDEAD;
    tick();
    check_eq("ecall_mepc", bus.mepc_o, 64'h80000020);
    check_eq("ecall_mtvec", bus.mtvec_o, 64'h80000100);
    bus.Csrwen = 1'b0;  bus.CsrId = 12'h342;  #1;
    check_eq("ecall_mcause", bus.csrres, 64'd11);
    bus.epc_in = 64'h80000040;
    tick();
    check_eq("ecall_nowen", bus.mepc_o, 64'h80000020);
    bus.Ecall = 1'b0;

    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.enable = ($urandom_range(0, 4) != 0);
      bus.valid_i = 1'($urandom());
      bus.instr_i = $urandom();
      bus.rd_i = 5'($urandom());
      k = $urandom_range(0, 20);
      if (k <= 10)      bus.ALUOp_i = 5'(k);
      else if (k <= 18) bus.ALUOp_i = 5'(k + 5);
      else if (k == 19) bus.ALUOp_i = 5'd11;
      else              bus.ALUOp_i = 5'($urandom_range(24, 31));
      bus.ALUSrcA_i = ($urandom_range(0, 3) == 0);
      bus.ALUSrcB_i = 2'($urandom());
      bus.MulOp_i = 2'($urandom());
      bus.pc_i = rand64();  bus.busa_i = rand64();  bus.busb_i = rand64();  bus.imm_i = rand64();
      bus.MemOp_i = 3'($urandom());  bus.MemToReg_i = 1'($urandom());  bus.MemWen_i = 1'($urandom());
      bus.wen_i = 1'($urandom());  bus.CsrToReg_i = 1'($urandom());  bus.Ebreak_i = 1'($urandom());
      bus.Csrres_i = rand64();
      bus.Csrwen = 1'($urandom());
      bus.Ecall = ($urandom_range(0, 7) == 0);
      bus.CsrOp = 3'($urandom());
      bus.CsrId = rand_csr_id();
      bus.datain = rand64();
      bus.epc_in = rand64();
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
